// File: rtl/dbus_merge_pkg.sv
// dbus_merge shared types.
// FSM state encoding and the round-robin wrap helper.
package dbus_merge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int rr_next(
    input int base,
    input int k,
    input int n
  );
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/dbus_merge_if.sv
// Upstream masters and downstream native memory port.
// master: the environment side; slave: the merge block.
interface dbus_merge_if #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256
);
  localparam int STRB_W = DATA_W / 8;

  logic [N_MASTERS-1:0]        m_valid;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS*STRB_W-1:0] m_wstrb;
  logic [DATA_W-1:0]           m_rdata;
  logic [N_MASTERS-1:0]        m_ready;

  logic                        s_valid;
  logic [ADDR_W-1:0]           s_addr;
  logic [DATA_W-1:0]           s_wdata;
  logic [STRB_W-1:0]           s_wstrb;
  logic [DATA_W-1:0]           s_rdata;
  logic                        s_ready;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_rdata, m_ready,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_rdata, s_ready
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_rdata, m_ready,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_rdata, s_ready
  );

endinterface

// File: rtl/dbus_merge_rr_arbiter.sv
// Combinational round-robin pick.
// Searches from last+1 upward, wrapping modulo N.
module rr_arbiter
  import dbus_merge_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = rr_next(int'(last), k, N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dbus_merge.sv
// Merges N data-bus masters onto one native memory port.
// One transaction at a time, round-robin, grant held until s_ready.
module dbus_merge
  import dbus_merge_pkg::*;
#(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256
) (
  input logic        clk,
  input logic        rst_n,
  dbus_merge_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IW     = $clog2(N_MASTERS);

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;

  logic [N_MASTERS-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;

  rr_arbiter #(.N(N_MASTERS)) u_arb (
    .req     (bus.m_valid),
    .last    (last_q),
    .gnt     (pick_oh),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    bus.s_valid = 1'b0;
    bus.m_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (|pick_oh) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus.s_valid = 1'b1;
        if (bus.s_ready) begin
          bus.m_ready[grant_q] = 1'b1;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe gated so an idle port never looks like a write.
  assign bus.s_addr  = bus.m_addr[grant_q*ADDR_W +: ADDR_W];
  assign bus.s_wdata = bus.m_wdata[grant_q*DATA_W +: DATA_W];
  assign bus.s_wstrb = bus.s_valid ?
                       bus.m_wstrb[grant_q*STRB_W +: STRB_W] : '0;
  assign bus.m_rdata = bus.s_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_dbus_merge.sv
// Directed self-checking bench for dbus_merge.
// Slave responses are driven by hand, step by step.
module tb_dbus_merge;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int SW = DW / 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  logic [DW-1:0] pat_a5;
  logic [DW-1:0] pat_dead;
  logic [DW-1:0] pat_m0;

  dbus_merge_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  dbus_merge #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string         tag,
    input logic [DW-1:0] obs,
    input logic [DW-1:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(
    input int            i,
    input logic [AW-1:0] a,
    input logic [DW-1:0] d,
    input logic [SW-1:0] s
  );
    bus.m_addr[i*AW +: AW]  = a;
    bus.m_wdata[i*DW +: DW] = d;
    bus.m_wstrb[i*SW +: SW] = s;
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    pat_a5   = {32{8'hA5}};
    pat_dead = {8{32'hDEADBEEF}};
    pat_m0   = {8{32'h01234567}};
    rst_n       = 1'b0;
    bus.m_valid = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.s_rdata = '0;
    bus.s_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", DW'(bus.s_valid), 0);
    chk("rst_m_ready", DW'(bus.m_ready), 0);
    chk("rst_s_wstrb", DW'(bus.s_wstrb), 0);
    rst_n = 1'b1;

    // Idle with no requests, then a spurious s_ready
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_s_valid", DW'(bus.s_valid), 0);
      chk("idle_m_ready", DW'(bus.m_ready), 0);
    end
    bus.s_ready = 1'b1;
    #1;
    chk("spur_m_ready", DW'(bus.m_ready), 0);
    step();
    bus.s_ready = 1'b0;
    chk("spur_s_valid", DW'(bus.s_valid), 0);

    // Master 1 read, slave answers 3 cycles after s_valid
    set_m(1, 32'h100, '0, '0);
    bus.m_valid = 3'b010;
    #1;
    chk("rd_no_comb", DW'(bus.s_valid), 0);
    step();
    chk("rd_s_valid", DW'(bus.s_valid), 1);
    chk("rd_s_addr", DW'(bus.s_addr), 32'h100);
    chk("rd_s_wstrb", DW'(bus.s_wstrb), 0);
    chk("rd_m_ready0", DW'(bus.m_ready), 0);
    step();
    step();
    chk("rd_hold", DW'(bus.s_valid), 1);
    bus.s_rdata = pat_a5;
    bus.s_ready = 1'b1;
    #1;
    chk("rd_m_ready", DW'(bus.m_ready), 3'b010);
    chk("rd_m_rdata", bus.m_rdata, pat_a5);
    step();
    bus.s_ready = 1'b0;
    bus.m_valid = '0;
    #1;
    chk("rd_done", DW'(bus.s_valid), 0);

    // All masters requesting from reset
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_m(i, AW'(32'h1000 + i), '0, '0);
    bus.m_valid = 3'b111;
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step();
      chk("rr_s_valid", DW'(bus.s_valid), 1);
      chk("rr_s_addr", DW'(bus.s_addr), DW'(32'h1000 + t % 3));
      bus.s_ready = 1'b1;
      #1;
      chk("rr_m_ready", DW'(bus.m_ready), DW'(1 << (t % 3)));
      step();
      bus.s_ready = 1'b0;
      #1;
      chk("rr_gap", DW'(bus.s_valid), 0);
    end
    bus.m_valid = '0;

    // Master 2 write, master 0 arrives mid-transaction
    set_m(2, 32'h2000, pat_dead, '1);
    bus.m_valid = 3'b100;
    step();
    chk("wr_s_valid", DW'(bus.s_valid), 1);
    chk("wr_s_wdata", bus.s_wdata, pat_dead);
    chk("wr_s_wstrb", DW'(bus.s_wstrb), DW'(32'hFFFF_FFFF));
    set_m(0, 32'h3000, pat_m0, '0);
    bus.m_valid = 3'b101;
    step();
    chk("wr_wdata_hold", bus.s_wdata, pat_dead);
    chk("wr_wstrb_hold", DW'(bus.s_wstrb), DW'(32'hFFFF_FFFF));
    chk("wr_addr_hold", DW'(bus.s_addr), 32'h2000);
    bus.s_ready = 1'b1;
    #1;
    chk("wr_m_ready", DW'(bus.m_ready), 3'b100);
    step();
    bus.s_ready = 1'b0;
    bus.m_valid = 3'b001;
    #1;
    chk("wr_gap_valid", DW'(bus.s_valid), 0);
    chk("wr_gap_wstrb", DW'(bus.s_wstrb), 0);
    step();
    chk("wr_next_addr", DW'(bus.s_addr), 32'h3000);
    chk("wr_next_wdata", bus.s_wdata, pat_m0);
    bus.s_ready = 1'b1;
    #1;
    chk("wr_next_ready", DW'(bus.m_ready), 3'b001);
    step();
    bus.s_ready = 1'b0;
    bus.m_valid = '0;
    #1;

    // Reset while busy with master 1
    set_m(1, 32'h4000, '0, '0);
    bus.m_valid = 3'b010;
    step();
    chk("rb_s_valid", DW'(bus.s_valid), 1);
    chk("rb_s_addr", DW'(bus.s_addr), 32'h4000);
    #3;
    rst_n = 1'b0;
    bus.s_ready = 1'b1;
    #1;
    chk("rb_rst_valid", DW'(bus.s_valid), 0);
    chk("rb_rst_ready", DW'(bus.m_ready), 0);
    step();
    bus.m_valid = 3'b001;
    rst_n = 1'b1;
    #1;
    chk("rb_spur_ready", DW'(bus.m_ready), 0);
    step();
    bus.s_ready = 1'b0;
    #1;
    chk("rb_s_valid2", DW'(bus.s_valid), 1);
    chk("rb_s_addr2", DW'(bus.s_addr), 32'h3000);

    // Master 0 continuous, master 2 raises once
    set_m(2, 32'h5000, '0, '0);
    bus.m_valid = 3'b101;
    bus.s_ready = 1'b1;
    #1;
    chk("fr_m_ready0", DW'(bus.m_ready), 3'b001);
    step();
    bus.s_ready = 1'b0;
    #1;
    chk("fr_gap", DW'(bus.s_valid), 0);
    step();
    chk("fr_addr2", DW'(bus.s_addr), 32'h5000);
    bus.s_ready = 1'b1;
    #1;
    chk("fr_m_ready2", DW'(bus.m_ready), 3'b100);
    step();
    bus.s_ready = 1'b0;
    bus.m_valid = 3'b001;
    step();
    chk("fr_addr0", DW'(bus.s_addr), 32'h3000);
    bus.s_ready = 1'b1;
    #1;
    chk("fr_m_ready0b", DW'(bus.m_ready), 3'b001);
    step();
    bus.s_ready = 1'b0;
    bus.m_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
